// File: rtl/si570_write_seq.sv
// Si570 boot-time configuration sequencer.
// Waits a power-up delay, then issues one I2C write (address, register, data) per table
// entry through a byte-level I2C master, retrying NACKed entries. Downstream reset is held
// until every entry has been acknowledged.
module si570_write_seq #(
    parameter logic [6:0]  DEV_ADDR   = 7'h55,
    parameter int unsigned NUM_WRITES = 8,
    parameter int unsigned BOOT_DELAY = 1000,
    parameter int unsigned RETRIES    = 3,
    parameter int unsigned RETRY_GAP  = 64
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] tbl_index,
    input  logic [7:0] tbl_reg,
    input  logic [7:0] tbl_data,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [7:0] cmd_data,
    output logic       cmd_start,
    output logic       cmd_stop,
    input  logic       rsp_valid,
    input  logic       rsp_ack,
    output logic       reset_out,
    output logic       busy,
    output logic       error
);

    typedef enum logic [2:0] {StBoot, StCmd, StRsp, StGap, StDone, StFail} state_e;

    localparam logic [7:0] LastIdx = 8'(NUM_WRITES - 1);

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;      // boot delay / retry gap counter
    logic [1:0]  bsel_q, bsel_d;    // byte within the current write
    logic [7:0]  idx_q, idx_d;
    logic [31:0] retry_q, retry_d;  // NACKs seen on the current entry
    logic        reset_out_q, reset_out_d;
    logic        busy_q, busy_d;
    logic        error_q, error_d;

    // State and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StBoot;
            cnt_q       <= '0;
            bsel_q      <= '0;
            idx_q       <= '0;
            retry_q     <= '0;
            reset_out_q <= 1'b1;
            busy_q      <= 1'b1;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bsel_q      <= bsel_d;
            idx_q       <= idx_d;
            retry_q     <= retry_d;
            reset_out_q <= reset_out_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
        end
    end

    // Sequencing: boot wait, byte handshakes, response handling and retry gaps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bsel_d  = bsel_q;
        idx_d   = idx_q;
        retry_d = retry_q;
        unique case (state_q)
            StBoot: begin
                if (cnt_q == BOOT_DELAY) begin
                    state_d = StCmd;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StCmd: begin
                if (cmd_ready) begin
                    state_d = StRsp;
                end
            end
            StRsp: begin
                if (rsp_valid) begin
                    if (rsp_ack) begin
                        if (bsel_q < 2'd2) begin
                            bsel_d  = bsel_q + 2'd1;
                            state_d = StCmd;
                        end else if (idx_q < LastIdx) begin
                            idx_d   = idx_q + 8'd1;
                            bsel_d  = 2'd0;
                            retry_d = '0;
                            state_d = StCmd;
                        end else begin
                            state_d = StDone;
                        end
                    end else if (retry_q < RETRIES) begin
                        // Restart the same entry from the address byte after a gap.
                        retry_d = retry_q + 32'd1;
                        bsel_d  = 2'd0;
                        cnt_d   = '0;
                        state_d = StGap;
                    end else begin
                        state_d = StFail;
                    end
                end
            end
            StGap: begin
                if (cnt_q == RETRY_GAP - 1) begin
                    state_d = StCmd;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StDone, StFail: begin
                state_d = state_q;
            end
            default: begin
                state_d = StBoot;
            end
        endcase
    end

    // Status outputs registered from the next state so they change with the state.
    always_comb begin
        reset_out_d = (state_d != StDone);
        busy_d      = (state_d != StDone) && (state_d != StFail);
        error_d     = (state_d == StFail);
    end

    // Byte command decode; table inputs pass through combinationally.
    always_comb begin
        cmd_data  = 8'h00;
        cmd_start = 1'b0;
        cmd_stop  = 1'b0;
        if (state_q == StCmd) begin
            unique case (bsel_q)
                2'd0: begin
                    cmd_data  = {DEV_ADDR, 1'b0};
                    cmd_start = 1'b1;
                end
                2'd1: cmd_data = tbl_reg;
                2'd2: begin
                    cmd_data = tbl_data;
                    cmd_stop = 1'b1;
                end
                default: cmd_data = 8'h00;
            endcase
        end
    end

    assign cmd_valid = (state_q == StCmd);
    assign tbl_index = idx_q;
    assign reset_out = reset_out_q;
    assign busy      = busy_q;
    assign error     = error_q;

endmodule

// File: tb/tb_si570_write_seq.sv
// Self-checking bench for si570_write_seq: an event-time model predicts every output each
// cycle, and a few hand-computed timing/byte expectations pin the model.
module tb_si570_write_seq;

    localparam logic [6:0]  DEV_ADDR   = 7'h55;
    localparam int unsigned NUM_WRITES = 3;
    localparam int unsigned BOOT_DELAY = 10;
    localparam int unsigned RETRIES    = 2;
    localparam int unsigned RETRY_GAP  = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tbl_index;
    logic [7:0] tbl_reg;
    logic [7:0] tbl_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_data;
    logic       cmd_start;
    logic       cmd_stop;
    logic       rsp_valid;
    logic       rsp_ack;
    logic       reset_out;
    logic       busy;
    logic       error;

    logic [7:0] treg [256];
    logic [7:0] tdat [256];

    assign tbl_reg  = treg[tbl_index];
    assign tbl_data = tdat[tbl_index];

    si570_write_seq #(
        .DEV_ADDR  (DEV_ADDR),
        .NUM_WRITES(NUM_WRITES),
        .BOOT_DELAY(BOOT_DELAY),
        .RETRIES   (RETRIES),
        .RETRY_GAP (RETRY_GAP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tbl_index(tbl_index),
        .tbl_reg  (tbl_reg),
        .tbl_data (tbl_data),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_data (cmd_data),
        .cmd_start(cmd_start),
        .cmd_stop (cmd_stop),
        .rsp_valid(rsp_valid),
        .rsp_ack  (rsp_ack),
        .reset_out(reset_out),
        .busy     (busy),
        .error    (error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: cycle numbers count rising edges since reset release.
    logic [7:0] m_entry;
    int         m_byte;
    int         m_tries;
    bit         m_out;      // byte accepted, response pending
    bit         m_done;
    bit         m_fail;
    int         m_from;     // first cycle the next byte must be offered
    int         rsp_due;
    int         end_n;
    int         bp;

    // Observations of the DUT for the literal expectations.
    int         obs_first_valid;
    logic [7:0] obs_hs[$];
    int         obs_starts;
    int         obs_bp;
    int         obs_reset_fall;
    int         obs_err_n;
    int         last_nack_n;
    int         obs_rise;
    logic [7:0] rise_data;
    logic       rise_start;
    logic       prev_valid;
    bit         finished;

    logic [7:0] exp_bytes [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit want_nack(input int mode);
        case (mode)
            1:       return (m_entry == 8'd1) && (m_byte == 2) && (m_tries == 0);
            2:       return (m_byte == 0);
            3:       return ($urandom_range(0, 5) == 0);
            default: return 1'b0;
        endcase
    endfunction

    task automatic check_cycle(input int n);
        bit         ev;
        logic [7:0] ed;
        ev = !m_done && !m_fail && !m_out && (n >= m_from);
        chk("cmd_valid", 32'(cmd_valid), 32'(ev));
        if (ev) begin
            ed = (m_byte == 0) ? {DEV_ADDR, 1'b0} : (m_byte == 1) ? treg[m_entry] : tdat[m_entry];
            chk("cmd_data", 32'(cmd_data), 32'(ed));
            chk("cmd_start", 32'(cmd_start), 32'(m_byte == 0));
            chk("cmd_stop", 32'(cmd_stop), 32'(m_byte == 2));
        end
        chk("tbl_index", 32'(tbl_index), 32'(m_entry));
        chk("reset_out", 32'(reset_out), 32'(!m_done));
        chk("busy", 32'(busy), 32'(!(m_done || m_fail)));
        chk("error", 32'(error), 32'(m_fail));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
        chk({tag, "_cmd_start"}, 32'(cmd_start), 32'd0);
        chk({tag, "_cmd_stop"}, 32'(cmd_stop), 32'd0);
        chk({tag, "_cmd_data"}, 32'(cmd_data), 32'd0);
        chk({tag, "_tbl_index"}, 32'(tbl_index), 32'd0);
        chk({tag, "_reset_out"}, 32'(reset_out), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_error"}, 32'(error), 32'd0);
    endtask

    // ack_mode: 0 all ACK, 1 one NACK on entry 1 byte 2, 2 NACK every address byte, 3 random.
    // rdy_mode: 0 always ready, 1 five-cycle stall on entry 0 byte 1, 2 random.
    task automatic run_seq(input int ack_mode, input int rdy_mode, input bit rand_lat,
                           input bit stray, input bit abort_mid);
        bit ev;
        int lat;
        reset     = 1'b1;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_ack   = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        m_entry = 8'd0; m_byte = 0; m_tries = 0; m_out = 1'b0; m_done = 1'b0; m_fail = 1'b0;
        m_from = BOOT_DELAY + 1; rsp_due = -1; end_n = 0; bp = 0;
        obs_first_valid = -1; obs_hs.delete(); obs_starts = 0; obs_bp = 0;
        obs_reset_fall = -1; obs_err_n = -1; last_nack_n = -1; obs_rise = -1;
        rise_data = 8'h00; rise_start = 1'b0; prev_valid = 1'b0; finished = 1'b0;
        reset = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if (n > 0) @(negedge clk);
            check_cycle(n);
            if (abort_mid && m_entry == 8'd2 && m_out) begin
                reset = 1'b1;
                #1;
                chk("mid_cmd_valid", 32'(cmd_valid), 32'd0);
                chk("mid_tbl_index", 32'(tbl_index), 32'd0);
                chk("mid_reset_out", 32'(reset_out), 32'd1);
                chk("mid_busy", 32'(busy), 32'd1);
                return;
            end
            // Drive inputs for the coming edge.
            ev = !m_done && !m_fail && !m_out && (n >= m_from);
            rsp_valid = 1'b0;
            rsp_ack   = 1'b0;
            case (rdy_mode)
                1: begin
                    if (ev && m_entry == 8'd0 && m_byte == 1 && bp < 5) begin
                        cmd_ready = 1'b0;
                        bp++;
                    end else begin
                        cmd_ready = 1'b1;
                    end
                end
                2:       cmd_ready = ($urandom_range(0, 2) != 0);
                default: cmd_ready = 1'b1;
            endcase
            if (m_out && n == rsp_due) begin
                rsp_valid = 1'b1;
                rsp_ack   = !want_nack(ack_mode);
                if (!rsp_ack) begin
                    last_nack_n = n;
                    obs_rise    = -1;
                end
            end else if (stray && !m_out && $urandom_range(0, 5) == 0) begin
                rsp_valid = 1'b1;
                rsp_ack   = 1'($urandom_range(0, 1));
            end
            // Observe DUT behaviour for the literal checks.
            if (cmd_valid === 1'b1 && obs_first_valid < 0) obs_first_valid = n;
            if (cmd_valid && cmd_ready) begin
                obs_hs.push_back(cmd_data);
                if (cmd_start) obs_starts++;
            end
            if (cmd_valid && !cmd_ready && cmd_data == 8'h89 && !cmd_start && !cmd_stop) obs_bp++;
            if (reset_out === 1'b0 && obs_reset_fall < 0) obs_reset_fall = n;
            if (error === 1'b1 && obs_err_n < 0) obs_err_n = n;
            if (last_nack_n >= 0 && obs_rise < 0 && cmd_valid && !prev_valid) begin
                obs_rise   = n;
                rise_data  = cmd_data;
                rise_start = cmd_start;
            end
            prev_valid = cmd_valid;
            // Advance the model on what the coming edge samples.
            if (!m_done && !m_fail) begin
                if (!m_out) begin
                    if (ev && cmd_ready) begin
                        lat     = rand_lat ? int'($urandom_range(1, 4)) : 2;
                        m_out   = 1'b1;
                        rsp_due = n + lat;
                    end
                end else if (rsp_valid) begin
                    m_out = 1'b0;
                    if (rsp_ack) begin
                        if (m_byte < 2) begin
                            m_byte++;
                            m_from = n + 1;
                        end else if (m_entry < 8'(NUM_WRITES - 1)) begin
                            m_entry++;
                            m_byte  = 0;
                            m_tries = 0;
                            m_from  = n + 1;
                        end else begin
                            m_done = 1'b1;
                            end_n  = n + 1;
                        end
                    end else if (m_tries < RETRIES) begin
                        m_tries++;
                        m_byte = 0;
                        m_from = n + 1 + RETRY_GAP;
                    end else begin
                        m_fail = 1'b1;
                        end_n  = n + 1;
                    end
                end
            end
            if ((m_done || m_fail) && n >= end_n + 30) begin
                finished = 1'b1;
                break;
            end
        end
        chk("seq_finished", 32'(finished), 32'd1);
    endtask

    task automatic load_nominal_table();
        treg[0] = 8'd137; tdat[0] = 8'h10;
        treg[1] = 8'd7;   tdat[1] = 8'h22;
        treg[2] = 8'd135; tdat[2] = 8'h40;
    endtask

    task automatic load_random_table();
        for (int i = 0; i < 3; i++) begin
            treg[i] = 8'($urandom);
            tdat[i] = 8'($urandom);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            treg[i] = 8'h00;
            tdat[i] = 8'h00;
        end
        exp_bytes = '{8'hAA, 8'h89, 8'h10, 8'hAA, 8'h07, 8'h22, 8'hAA, 8'h87, 8'h40};
        reset     = 1'b1;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_ack   = 1'b0;

        // Nominal run.
        load_nominal_table();
        run_seq(0, 0, 1'b0, 1'b0, 1'b0);
        chk("nom_first_valid", 32'(obs_first_valid), 32'd11);
        chk("nom_byte_count", 32'(obs_hs.size()), 32'd9);
        for (int i = 0; i < 9 && i < obs_hs.size(); i++) begin
            chk($sformatf("nom_byte%0d", i), 32'(obs_hs[i]), 32'(exp_bytes[i]));
        end
        chk("nom_reset_fall", 32'(obs_reset_fall), 32'd38);

        // Backpressure on entry 0 byte 1.
        run_seq(0, 1, 1'b0, 1'b0, 1'b0);
        chk("bp_stall_cycles", 32'(obs_bp), 32'd5);
        chk("bp_byte_count", 32'(obs_hs.size()), 32'd9);

        // Single NACK on entry 1 byte 2.
        run_seq(1, 0, 1'b0, 1'b0, 1'b0);
        chk("nack_reissue_delay", 32'(obs_rise - last_nack_n), 32'd5);
        chk("nack_reissue_data", 32'(rise_data), 32'hAA);
        chk("nack_reissue_start", 32'(rise_start), 32'd1);
        chk("nack_error", 32'(error), 32'd0);
        chk("nack_completed", 32'(obs_reset_fall >= 0), 32'd1);

        // Retry exhaustion: every address byte NACKed.
        run_seq(2, 0, 1'b0, 1'b0, 1'b0);
        chk("exh_attempts", 32'(obs_starts), 32'd3);
        chk("exh_handshakes", 32'(obs_hs.size()), 32'd3);
        chk("exh_error_delay", 32'(obs_err_n - last_nack_n), 32'd1);
        chk("exh_reset_out", 32'(reset_out), 32'd1);

        // Reset while waiting on entry 2, then a full repeat.
        load_random_table();
        run_seq(0, 2, 1'b1, 1'b0, 1'b1);
        run_seq(0, 2, 1'b1, 1'b0, 1'b0);
        chk("rerun_bytes", 32'(obs_hs.size()), 32'd9);
        chk("rerun_done", 32'(obs_reset_fall >= 0), 32'd1);

        // Stray responses in BOOT/CMD/GAP with random ready and latency.
        for (int r = 0; r < 2; r++) begin
            load_random_table();
            run_seq(0, 2, 1'b1, 1'b1, 1'b0);
        end
        // Random NACKs plus stray responses.
        for (int r = 0; r < 4; r++) begin
            load_random_table();
            run_seq(3, 2, 1'b1, 1'b1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/si570_write_seq.md
# si570_write_seq

Boot-time configuration sequencer for the Si570 programmable oscillator. After reset it waits a power-up delay, then walks a table of register/data pairs. Each pair goes out as one I2C write transaction (device address, register, data) through a byte-level I2C master. It holds `reset_out` asserted until every write has been acknowledged, so downstream logic stays in reset until the reference clock is programmed. It sits between the board reset and the shared I2C byte master that drives `sda`/`scl`.

## Interface
Parameters:
- `DEV_ADDR`, 7'h55: 7-bit I2C slave address of the Si570.
- `NUM_WRITES`, 8: number of table entries to issue, 1..255.
- `BOOT_DELAY`, 1000: idle cycles after reset release before the first command. 0 is legal.
- `RETRIES`, 3: extra attempts per write after a NACK. 0 means no retry.
- `RETRY_GAP`, 64: idle cycles between a NACK and the retry, ≥1.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `tbl_index`  out  8  index of the current table entry.
- `tbl_reg`  in  8  register address for `tbl_index`; combinational, valid the same cycle.
- `tbl_data`  in  8  data byte for `tbl_index`; combinational, valid the same cycle.
- `cmd_valid`  out  1  byte command valid.
- `cmd_ready`  in  1  master accepts the command when `cmd_valid && cmd_ready`.
- `cmd_data`  out  8  byte to transmit.
- `cmd_start`  out  1  generate START before this byte.
- `cmd_stop`  out  1  generate STOP after this byte.
- `rsp_valid`  in  1  one-cycle pulse: byte finished.
- `rsp_ack`  in  1  qualified by `rsp_valid`: 1 = ACK, 0 = NACK. On a NACK the master issues STOP itself.
- `reset_out`  out  1  active-high downstream reset.
- `busy`  out  1  high while the sequence is in progress.
- `error`  out  1  sticky; high when retries are exhausted.

## Operation
- States:
  - BOOT: count `BOOT_DELAY`.
  - CMD: `cmd_valid` = 1.
  - RSP: wait for `rsp_valid`.
  - GAP: count `RETRY_GAP`.
  - DONE.
  - FAIL.
- Byte counter `bsel` (0..2) selects the byte being sent:
  - 0: `{DEV_ADDR,1'b0}`, `cmd_start` = 1.
  - 1: `tbl_reg`.
  - 2: `tbl_data`, `cmd_stop` = 1.
  - `cmd_start` and `cmd_stop` are 0 for every other byte.
- BOOT → CMD when the delay counter reaches `BOOT_DELAY`. With `BOOT_DELAY` = 0, enter CMD on the first cycle after reset release.
- CMD → RSP on handshake. `cmd_data`, `cmd_start` and `cmd_stop` are stable while `cmd_valid && !cmd_ready`.
- RSP with `rsp_valid && rsp_ack`:
  - `bsel` < 2: `bsel++`, go to CMD.
  - `bsel` = 2 and `tbl_index` < `NUM_WRITES`-1: `tbl_index++`, `bsel` = 0, clear the retry counter, go to CMD.
  - `bsel` = 2 and `tbl_index` = `NUM_WRITES`-1: go to DONE.
- RSP with `rsp_valid && !rsp_ack`:
  - Retry counter < `RETRIES`: increment it, `bsel` = 0, go to GAP. The same `tbl_index` is restarted from byte 0.
  - Otherwise: go to FAIL.
- GAP → CMD after `RETRY_GAP` cycles.
- DONE and FAIL are terminal until `reset`.
- The retry count is per entry and is reset on each successful entry.
- `rsp_valid` outside RSP is ignored. `cmd_ready` outside CMD is ignored.

## Timing
- Reset values: `reset_out` = 1, `busy` = 1, `error` = 0, `cmd_valid` = 0, `cmd_start` = 0, `cmd_stop` = 0, `cmd_data` = 0, `tbl_index` = 0. State = BOOT, counters = 0.
- All outputs are registered. `cmd_*` fields are derived from registered state and registered `tbl_index`; `tbl_*` inputs feed `cmd_data` combinationally.
- First `cmd_valid` rises `BOOT_DELAY`+1 cycles after `reset` falls.
- After the handshake cycle, `cmd_valid` is 0 the next cycle. After an ACK pulse, `cmd_valid` rises the next cycle; there is no back-to-back reuse.
- After a NACK pulse, `cmd_valid` rises `RETRY_GAP`+1 cycles later.
- DONE entry: the cycle after the final ACK, `reset_out` = 0 and `busy` = 0. Both are held until reset.
- FAIL entry: the cycle after the final NACK, `error` = 1 and `busy` = 0. `reset_out` stays 1.
- Asynchronous `reset` mid-transaction immediately drops `cmd_valid` and restarts from BOOT. The master is responsible for bus recovery.

## Test plan
- Nominal run: `BOOT_DELAY` = 10, `NUM_WRITES` = 3, table {(137,0x10),(7,0x22),(135,0x40)}, `cmd_ready` always 1, ACK 2 cycles after each handshake.
  - First `cmd_valid` 11 cycles after reset release.
  - 9 bytes in order: 0xAA(start), 0x89, 0x10(stop), 0xAA, 0x07, 0x22, 0xAA, 0x87, 0x40.
  - `reset_out` falls the cycle after the 9th ACK.
- Backpressure: hold `cmd_ready` = 0 for 5 cycles on byte 1 → `cmd_valid`, `cmd_data` = 0x89, `cmd_start` = 0 and `cmd_stop` = 0 stable for all 5 cycles; exactly one handshake.
- Single NACK: NACK on entry 1, byte 2, with `RETRY_GAP` = 4 → 0xAA with `cmd_start` = 1 reissued 5 cycles after the NACK; entry 1 completes; `error` stays 0.
- Retry exhaustion: `RETRIES` = 2, NACK every device-address byte → exactly 3 attempts, `error` = 1 the cycle after the 3rd NACK, `reset_out` = 1, no further `cmd_valid`.
- Reset mid-run: assert `reset` while in RSP on entry 2 → same cycle `cmd_valid` = 0, `tbl_index` = 0, `reset_out` = 1; after release the full sequence repeats from entry 0.
- Stray response: `rsp_valid` pulse during BOOT and during CMD → no state change; the sequence is still correct.
